// File: rtl/tag_free_list.sv
// tag_free_list
//   Free list of physical rename tags with one branch checkpoint.
//   Tags are handed out lowest-index first, returned over CDB_PORTS
//   completion channels, and tags allocated under an open checkpoint are
//   reclaimed in one cycle when the branch turns out to be mispredicted.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   alloc_req         : dispatch asks for a tag
//   alloc_tag         : lowest free tag (0 when none free)
//   alloc_valid       : at least one tag free
//   alloc_gnt         : a tag is taken this cycle
//   cdb_tag/cdb_valid : per-port tag returns, port p at [p*TAG_WIDTH +: TAG_WIDTH]
//   br_dispatch       : open a checkpoint
//   br_resolve        : close the checkpoint
//   br_mispredict     : with br_resolve, squash speculative tags
//   br_stall          : checkpoint open, hold further branches
//   free_count        : registered number of free tags
//   empty             : no tag free
//   err_double_free   : one-cycle pulse after an illegal return
module tag_free_list #(
    parameter int TAG_WIDTH = 6,
    parameter int NUM_TAGS  = 64,
    parameter int CDB_PORTS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_req,
    output logic [TAG_WIDTH-1:0]           alloc_tag,
    output logic                           alloc_valid,
    output logic                           alloc_gnt,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic                           br_dispatch,
    input  logic                           br_resolve,
    input  logic                           br_mispredict,
    output logic                           br_stall,
    output logic [TAG_WIDTH:0]             free_count,
    output logic                           empty,
    output logic                           err_double_free
);

    typedef enum logic {IDLE, SPEC} state_t;

    localparam logic [TAG_WIDTH:0] TAG_LIMIT = (TAG_WIDTH + 1)'(NUM_TAGS);

    state_t                state, state_n;
    logic [NUM_TAGS-1:0]   free_vec, free_n;
    logic [NUM_TAGS-1:0]   spec_vec, spec_n;
    logic [NUM_TAGS-1:0]   gnt_mask, ret_mask, ret_onehot;
    logic [TAG_WIDTH-1:0]  ret_tag;
    logic [TAG_WIDTH:0]    count_n;
    logic                  err_n;
    logic                  squash;

    // Lowest-index free tag; scanning downward lets the lowest hit win.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_tag = TAG_WIDTH'(i);
        end
    end

    assign alloc_valid = |free_vec;
    assign empty       = ~alloc_valid;
    assign br_stall    = (state == SPEC);
    assign squash      = br_resolve & br_mispredict & (state == SPEC);
    // A squash rewinds the list, so nothing may be handed out that cycle.
    assign alloc_gnt   = alloc_req & alloc_valid & ~squash;
    assign gnt_mask    = alloc_gnt ? (NUM_TAGS'(1) << alloc_tag) : '0;

    // Returns are checked in port order against the registered free vector
    // plus earlier ports of the same cycle, so a tag returned twice at once
    // is accepted once and flagged once.
    always_comb begin
        ret_mask   = '0;
        ret_onehot = '0;
        ret_tag    = '0;
        err_n      = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
                ret_tag    = cdb_tag[p*TAG_WIDTH +: TAG_WIDTH];
                ret_onehot = NUM_TAGS'(1) << ret_tag;
                if (({1'b0, ret_tag} >= TAG_LIMIT) ||
                    (|(ret_onehot & (free_vec | ret_mask)))) begin
                    err_n = 1'b1;
                end else begin
                    ret_mask = ret_mask | ret_onehot;
                end
            end
        end
    end

    // Checkpoint FSM and next free / speculative vectors.
    always_comb begin
        state_n = state;
        free_n  = (free_vec & ~gnt_mask) | ret_mask;
        spec_n  = spec_vec & ~ret_mask;
        case (state)
            IDLE: begin
                // The grant in the dispatch cycle predates the branch.
                if (br_dispatch) begin
                    state_n = SPEC;
                    spec_n  = '0;
                end
            end
            SPEC: begin
                if (br_resolve) begin
                    if (br_mispredict) free_n = free_n | spec_vec;
                    spec_n  = '0;
                    state_n = br_dispatch ? SPEC : IDLE;
                end else begin
                    spec_n = (spec_vec | gnt_mask) & ~ret_mask;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        count_n = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            count_n = count_n + (TAG_WIDTH + 1)'(free_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            free_vec        <= '1;
            spec_vec        <= '0;
            free_count      <= TAG_LIMIT;
            err_double_free <= 1'b0;
        end else begin
            state           <= state_n;
            free_vec        <= free_n;
            spec_vec        <= spec_n;
            free_count      <= count_n;
            err_double_free <= err_n;
        end
    end

endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list
//   Directed bench for tag_free_list with two CDB ports. Granted tags are
//   checked against a queue of expected tags filled as requests are driven.
module tb_tag_free_list;

    localparam int TW = 6;
    localparam int NT = 64;
    localparam int CP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req;
    logic [TW-1:0]     alloc_tag;
    logic              alloc_valid;
    logic              alloc_gnt;
    logic [CP*TW-1:0]  cdb_tag;
    logic [CP-1:0]     cdb_valid;
    logic              br_dispatch;
    logic              br_resolve;
    logic              br_mispredict;
    logic              br_stall;
    logic [TW:0]       free_count;
    logic              empty;
    logic              err_double_free;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    tag_free_list #(.TAG_WIDTH(TW), .NUM_TAGS(NT), .CDB_PORTS(CP)) dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_tag(alloc_tag),
        .alloc_valid(alloc_valid), .alloc_gnt(alloc_gnt), .cdb_tag(cdb_tag),
        .cdb_valid(cdb_valid), .br_dispatch(br_dispatch), .br_resolve(br_resolve),
        .br_mispredict(br_mispredict), .br_stall(br_stall), .free_count(free_count),
        .empty(empty), .err_double_free(err_double_free)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_req     = 1'b0;
        cdb_tag       = '0;
        cdb_valid     = '0;
        br_dispatch   = 1'b0;
        br_resolve    = 1'b0;
        br_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        #1;
        chk({tag, "_free_count"}, 32'(free_count), 32'(NT));
        chk({tag, "_err"},        32'(err_double_free), 32'd0);
        chk({tag, "_br_stall"},   32'(br_stall), 32'd0);
        chk({tag, "_alloc_tag"},  32'(alloc_tag), 32'd0);
        chk({tag, "_alloc_valid"},32'(alloc_valid), 32'd1);
        chk({tag, "_empty"},      32'(empty), 32'd0);
    endtask

    // Request n consecutive tags, expecting first, first+1, ...
    task automatic alloc_run(input int n, input int first);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(first + k);
            alloc_req = 1'b1;
            #1;
            chk("alloc_gnt", 32'(alloc_gnt), 32'd1);
            chk("alloc_tag", 32'(alloc_tag), 32'(exp_q.pop_front()));
            tick();
        end
        alloc_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();

        // Reset values
        do_reset();
        check_reset_vals("reset");

        // Drain all 64 tags in order
        alloc_run(64, 0);
        alloc_req = 1'b1;
        #1;
        chk("drain_empty",       32'(empty), 32'd1);
        chk("drain_alloc_valid", 32'(alloc_valid), 32'd0);
        chk("drain_free_count",  32'(free_count), 32'd0);
        chk("drain_alloc_gnt",   32'(alloc_gnt), 32'd0);
        tick();
        alloc_req = 1'b0;
        chk("drain_no_err", 32'(err_double_free), 32'd0);

        // Allocate 0..3, return tag 2
        do_reset();
        alloc_run(4, 0);
        chk("ret_fc_before", 32'(free_count), 32'd60);
        cdb_tag   = {6'd0, 6'd2};
        cdb_valid = 2'b01;
        #1;
        chk("ret_same_cycle_tag", 32'(alloc_tag), 32'd4);
        tick();
        clear_inputs();
        chk("ret_fc_after", 32'(free_count), 32'd61);
        chk("ret_alloc_tag", 32'(alloc_tag), 32'd2);
        chk("ret_no_err", 32'(err_double_free), 32'd0);

        // Mispredict squashes 5,6,7
        do_reset();
        alloc_run(5, 0);
        br_dispatch = 1'b1;
        tick();
        br_dispatch = 1'b0;
        chk("mp_stall_open", 32'(br_stall), 32'd1);
        alloc_run(3, 5);
        chk("mp_fc_spec", 32'(free_count), 32'd56);
        br_resolve = 1'b1; br_mispredict = 1'b1; alloc_req = 1'b1;
        #1;
        chk("mp_gnt_blocked", 32'(alloc_gnt), 32'd0);
        tick();
        clear_inputs();
        chk("mp_stall_closed", 32'(br_stall), 32'd0);
        chk("mp_fc_after", 32'(free_count), 32'd59);
        chk("mp_alloc_tag", 32'(alloc_tag), 32'd5);

        // Grant in the dispatch cycle is not speculative
        do_reset();
        br_dispatch = 1'b1;
        alloc_run(1, 0);
        br_dispatch = 1'b0;
        alloc_run(1, 1);
        br_resolve = 1'b1; br_mispredict = 1'b1;
        tick();
        clear_inputs();
        chk("disp_fc", 32'(free_count), 32'd63);
        chk("disp_alloc_tag", 32'(alloc_tag), 32'd1);

        // Allocate 8 under checkpoint, return it, correct resolve
        do_reset();
        alloc_run(8, 0);
        br_dispatch = 1'b1;
        tick();
        br_dispatch = 1'b0;
        alloc_run(1, 8);
        cdb_tag   = {6'd8, 6'd0};
        cdb_valid = 2'b10;
        tick();
        clear_inputs();
        chk("cr_fc_ret", 32'(free_count), 32'd56);
        chk("cr_tag8_free", 32'(alloc_tag), 32'd8);
        chk("cr_no_err", 32'(err_double_free), 32'd0);
        br_resolve = 1'b1;
        tick();
        clear_inputs();
        chk("cr_stall", 32'(br_stall), 32'd0);
        chk("cr_fc_resolve", 32'(free_count), 32'd56);

        // Resolve plus dispatch in SPEC re-opens with a cleared checkpoint
        br_dispatch = 1'b1;
        tick();
        br_dispatch = 1'b0;
        alloc_run(1, 8);
        br_dispatch = 1'b1; br_resolve = 1'b1;
        tick();
        clear_inputs();
        chk("reopen_stall", 32'(br_stall), 32'd1);
        alloc_run(1, 9);
        br_resolve = 1'b1; br_mispredict = 1'b1;
        tick();
        clear_inputs();
        chk("reopen_fc", 32'(free_count), 32'd55);
        chk("reopen_alloc_tag", 32'(alloc_tag), 32'd9);

        // Return of an already free tag on port 1
        do_reset();
        cdb_tag   = {6'd10, 6'd0};
        cdb_valid = 2'b10;
        tick();
        clear_inputs();
        chk("dbl_err_pulse", 32'(err_double_free), 32'd1);
        chk("dbl_fc", 32'(free_count), 32'd64);
        tick();
        chk("dbl_err_clear", 32'(err_double_free), 32'd0);

        // Same tag returned on both ports in one cycle
        alloc_run(1, 0);
        cdb_tag   = {6'd0, 6'd0};
        cdb_valid = 2'b11;
        tick();
        clear_inputs();
        chk("dual_err", 32'(err_double_free), 32'd1);
        chk("dual_fc", 32'(free_count), 32'd64);
        chk("dual_alloc_tag", 32'(alloc_tag), 32'd0);

        // Reset mid-speculation overrides everything
        do_reset();
        br_dispatch = 1'b1;
        tick();
        br_dispatch = 1'b0;
        alloc_run(3, 0);
        chk("rs_fc_spec", 32'(free_count), 32'd61);
        chk("rs_stall_spec", 32'(br_stall), 32'd1);
        reset = 1'b1; alloc_req = 1'b1;
        cdb_tag = {6'd0, 6'd20}; cdb_valid = 2'b01;
        tick();
        reset = 1'b0;
        clear_inputs();
        check_reset_vals("rs");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_free_list.md
TAG_FREE_LIST -- requirements
Module: tag_free_list

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 6: width of a rename tag.
REQ-002 SHALL have parameter NUM_TAGS, default 64: number of tags managed; legal range 2..2^TAG_WIDTH.
REQ-003 SHALL have parameter CDB_PORTS, default 1: number of CDB tag-return channels; legal range 1..4.
REQ-004 SHALL have one clock and a synchronous active-high reset, fixed as follows:
- clk  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high.
REQ-005 SHALL have the following ports:
- alloc_req  in  1: dispatch requests a tag for a register-writing instruction.
- alloc_tag  out  TAG_WIDTH: tag offered this cycle.
- alloc_valid  out  1: at least one tag free.
- alloc_gnt  out  1: allocation accepted this cycle.
- cdb_tag  in  CDB_PORTS*TAG_WIDTH: returned tags, port p at bits [p*TAG_WIDTH +: TAG_WIDTH].
- cdb_valid  in  CDB_PORTS: per-port return strobe.
- br_dispatch  in  1: branch dispatched; open checkpoint.
- br_resolve  in  1: outstanding branch resolved.
- br_mispredict  in  1: qualifies br_resolve; squash speculative tags.
- br_stall  out  1: checkpoint open; dispatch must hold further branches.
- free_count  out  TAG_WIDTH+1: number of free tags.
- empty  out  1: no tag free.
- err_double_free  out  1: one-cycle pulse on an illegal return.

Function
REQ-006 SHALL hold a NUM_TAGS-bit free vector (bit i = tag i free) and a NUM_TAGS-bit speculative vector.
REQ-007 SHALL drive alloc_tag combinationally as the lowest-index set bit of the registered free vector, and as 0 when none is set.
REQ-008 SHALL drive alloc_valid = OR of the free vector, and empty = NOT alloc_valid.
REQ-009 SHALL drive alloc_gnt = alloc_req AND alloc_valid AND NOT (br_resolve AND br_mispredict AND state==SPEC).
- On alloc_gnt the bit for alloc_tag SHALL clear at the next edge.
- alloc_req while empty SHALL be ignored and SHALL NOT flag an error.
REQ-010 SHALL, for each port p with cdb_valid[p]=1 and tag < NUM_TAGS, set that free bit at the next edge.
- A return never makes a tag allocatable in the same cycle; allocation latency after a return is 1 cycle.
- The returned tag's speculative bit SHALL also clear.
REQ-011 SHALL, when a returned tag is already free or is >= NUM_TAGS, leave state unchanged for that port and assert err_double_free for exactly the following cycle.
- Two ports returning the same allocated tag in one cycle: one return is legal and the second is an error.
REQ-012 SHALL apply alloc_gnt and all legal returns in the same cycle independently; these never target the same tag.
REQ-013 SHALL implement a two-state FSM, IDLE and SPEC, with br_stall = (state==SPEC):
- IDLE with br_dispatch -> SPEC, and the speculative vector clears.
- An allocation in the br_dispatch cycle SHALL NOT be marked speculative.
- IDLE with br_resolve: ignored.
REQ-014 SHALL, in SPEC, set the speculative bit of every granted tag.
REQ-015 SHALL, in SPEC with br_resolve=1 and br_mispredict=0, go to IDLE and clear the speculative vector; the free vector is unchanged.
REQ-016 SHALL, in SPEC with br_resolve=1 and br_mispredict=1, go to IDLE and OR the speculative vector into the free vector.
- The speculative vector clears; alloc_gnt is 0 this cycle.
- Legal CDB returns in the same cycle still apply.
REQ-017 SHALL ignore br_dispatch in SPEC unless br_resolve is asserted in the same cycle; in that case the resolve is processed and the FSM re-enters SPEC with a cleared speculative vector.
REQ-018 SHALL register free_count as the population count of the next free vector.
REQ-019 SHALL treat no CDB returns for squashed tags after the mispredict cycle as an upstream guarantee; such returns are flagged per REQ-011.

Reset
REQ-020 SHALL, on reset, take effect at the next edge and override all other inputs, including mid-speculation:
- free vector all ones; speculative vector 0; state IDLE.
- free_count=NUM_TAGS; err_double_free=0; br_stall=0.
- alloc_tag=0; alloc_valid=1; empty=0.

Verification
REQ-021 SHALL cover reset, then alloc_req high for 64 cycles (defaults):
- tags 0..63 granted in order; then empty=1, free_count=0, alloc_gnt=0.
REQ-022 SHALL cover allocate tags 0..3, then return tag 2 on cdb port 0:
- free_count 60 -> 61; next alloc_tag=2 one cycle later.
REQ-023 SHALL cover br_dispatch, allocate tags 5,6,7 in SPEC, then br_resolve+br_mispredict with alloc_req high:
- alloc_gnt=0 that cycle; tags 5,6,7 free next cycle; br_stall 1 -> 0.
REQ-024 SHALL cover br_dispatch, allocate tag 8, return tag 8, then correct resolve:
- tag 8 free; speculative vector 0; state IDLE.
REQ-025 SHALL cover CDB_PORTS=2, returning free tag 10 on port 1:
- err_double_free pulses for 1 cycle; free_count unchanged.
REQ-026 SHALL cover reset asserted in SPEC with 3 speculative tags outstanding:
- all reset values of REQ-020 next cycle.
